// File: rtl/flash_reader.sv
// rtl/flash_reader.sv - SPI flash read sequencer: CS, command, 24-bit address, then LEN data bytes.
// Define FLASH_FAST_READ_EN for fast read (0x0B) with one dummy byte before data.
module flash_reader #(
  parameter int SLOT = 20,
  parameter int CSW  = 2,
  parameter int LW   = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          start,
  input  logic [23:0]   addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          dv,
  output logic [7:0]    q,
  output logic          fshCs,
  output logic          spiTx,
  output logic          spiRx,
  output logic [7:0]    spiD,
  input  logic [7:0]    spiQ
);

  localparam int TMAX = (SLOT > CSW) ? SLOT : CSW;
  localparam int TW   = $clog2(TMAX);

`ifdef FLASH_FAST_READ_EN
  typedef enum logic [3:0] {IDLE, CSLO, CMD, A2, A1, A0, DUMMY, DATA, CSHI} stateT;
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  typedef enum logic [3:0] {IDLE, CSLO, CMD, A2, A1, A0, DATA, CSHI} stateT;
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  stateT         state, stateNext;
  logic [TW-1:0] timer, timerNext;
  logic [LW-1:0] byteCnt, cntNext, cntInc;
  logic [23:0]   addrR;
  logic [LW-1:0] lenR;
  logic          slotEnd, csloEnd, finishing, capture;

  assign slotEnd   = (timer == TW'(SLOT - 1));
  assign csloEnd   = (timer == TW'(CSW - 1));
  assign cntInc    = byteCnt + LW'(1);
  assign finishing = (stateNext == CSHI) && (state != CSHI);
  assign capture   = ce && (state == DATA) && slotEnd;

  always_comb begin
    stateNext = state;
    timerNext = timer;
    cntNext   = byteCnt;
    if (ce) begin
      case (state)
        IDLE, CSHI: begin
          timerNext = '0;
          cntNext   = '0;
          stateNext = busy ? CSLO : IDLE;
        end
        CSLO: begin
          timerNext = csloEnd ? '0 : timer + TW'(1);
          if (csloEnd) stateNext = CMD;
        end
        CMD, A2, A1: begin
          timerNext = slotEnd ? '0 : timer + TW'(1);
          if (slotEnd) stateNext = (state == CMD) ? A2 : (state == A2) ? A1 : A0;
        end
`ifdef FLASH_FAST_READ_EN
        A0: begin
          timerNext = slotEnd ? '0 : timer + TW'(1);
          if (slotEnd) stateNext = DUMMY;
        end
        DUMMY: begin
          timerNext = slotEnd ? '0 : timer + TW'(1);
          if (slotEnd) stateNext = (lenR == '0) ? CSHI : DATA;
        end
`else
        A0: begin
          timerNext = slotEnd ? '0 : timer + TW'(1);
          if (slotEnd) stateNext = (lenR == '0) ? CSHI : DATA;
        end
`endif
        DATA: begin
          timerNext = slotEnd ? '0 : timer + TW'(1);
          if (slotEnd) begin
            cntNext = cntInc;
            if (cntInc == lenR) stateNext = CSHI;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Bus-facing outputs decode straight from state so a reset drops CS on the same edge
  always_comb begin
    fshCs = 1'b0;
    spiTx = 1'b0;
    spiRx = 1'b0;
    spiD  = 8'h00;
    case (state)
      IDLE, CSHI: fshCs = 1'b1;
      CMD: begin spiD = READ_CMD;     spiTx = (timer == '0); end
      A2:  begin spiD = addrR[23:16]; spiTx = (timer == '0); end
      A1:  begin spiD = addrR[15:8];  spiTx = (timer == '0); end
      A0:  begin spiD = addrR[7:0];   spiTx = (timer == '0); end
`ifdef FLASH_FAST_READ_EN
      DUMMY: spiTx = (timer == '0);
`endif
      DATA: spiRx = (timer == '0);
      default: fshCs = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      byteCnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dv      <= 1'b0;
      q       <= 8'h00;
      addrR   <= '0;
      lenR    <= '0;
    end else begin
      state   <= stateNext;
      timer   <= timerNext;
      byteCnt <= cntNext;
      done    <= finishing;
      dv      <= capture;
      if (capture) q <= spiQ;
      // A start arriving while busy (including on the done edge) is dropped
      if (start && !busy) begin
        busy  <= 1'b1;
        addrR <= addr;
        lenR  <= len;
      end else if (finishing) begin
        busy  <= 1'b0;
      end
    end
  end

endmodule
